// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, register
// constants and the packed control-output bundle with its canned patterns.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hazState_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  // Instruction word a flushed buffer is cleared to (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pcEn;
    logic pcSel;
    logic ifidEn;
    logic ifidFlush;
    logic idexEn;
    logic idexFlush;
    logic exmemEn;
    logic exmemFlush;
    logic memwbEn;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = '{pcEn: 1'b1, pcSel: 1'b0, ifidEn: 1'b1, ifidFlush: 1'b0,
                                     idexEn: 1'b1, idexFlush: 1'b0, exmemEn: 1'b1,
                                     exmemFlush: 1'b0, memwbEn: 1'b1};
  localparam ctrl_t CTRL_RESET   = '{pcEn: 1'b0, pcSel: 1'b0, ifidEn: 1'b0, ifidFlush: 1'b1,
                                     idexEn: 1'b0, idexFlush: 1'b1, exmemEn: 1'b0,
                                     exmemFlush: 1'b1, memwbEn: 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{pcEn: 1'b0, pcSel: 1'b0, ifidEn: 1'b0, ifidFlush: 1'b0,
                                     idexEn: 1'b0, idexFlush: 1'b0, exmemEn: 1'b0,
                                     exmemFlush: 1'b0, memwbEn: 1'b0};
  // Branch squashes the three younger instructions while the branch itself retires.
  localparam ctrl_t CTRL_BRANCH  = '{pcEn: 1'b1, pcSel: 1'b1, ifidEn: 1'b1, ifidFlush: 1'b1,
                                     idexEn: 1'b1, idexFlush: 1'b1, exmemEn: 1'b1,
                                     exmemFlush: 1'b1, memwbEn: 1'b1};
  localparam ctrl_t CTRL_LOADUSE = '{pcEn: 1'b0, pcSel: 1'b0, ifidEn: 1'b0, ifidFlush: 1'b0,
                                     idexEn: 1'b1, idexFlush: 1'b1, exmemEn: 1'b1,
                                     exmemFlush: 1'b0, memwbEn: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       exMemRead,
  input  logic [4:0] exRt,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  output logic       hazard
);

  // $zero is never really written, so a load targeting it cannot create a dependency.
  assign hazard = exMemRead && (exRt != REG_ZERO) && ((exRt == idRs) || (exRt == idRt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-stage enable/flush sequencer for the 5-stage pipeline: memory-wait freeze,
// taken-branch flush and load-use bubble, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zf,
  input  logic             mem_access,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic [CNT_W-1:0] stall_cycles,
  output hazState_e        dbgState,
  output logic [3:0]       dbgCnt
);

  localparam int         LAT_CLAMP = (MEM_LAT > 15) ? 15 : MEM_LAT;
  localparam bit         FREEZE_ON = (LAT_CLAMP > 0);
  localparam logic [3:0] LAT_LOAD  = FREEZE_ON ? 4'(LAT_CLAMP - 1) : 4'd0;

  hazState_e        state, nextState;
  logic [3:0]       cnt, nextCnt;
  logic [CNT_W-1:0] stallCnt;
  logic             loadUse;
  logic             branchTaken;
  logic             freeze;
  ctrl_t            ctrl;

  load_use_detect uLoadUse (
    .exMemRead (ex_mem_read),
    .exRt      (ex_rt),
    .idRs      (id_rs),
    .idRt      (id_rt),
    .hazard    (loadUse)
  );

  assign branchTaken = mem_branch && mem_zf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= 4'd0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // cnt holds the remaining freeze cycles after the current one; the release
  // cycle (MEM_WAIT, cnt==0) lets the access advance regardless of mem_access.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    freeze    = 1'b0;
    if (FREEZE_ON) begin
      case (state)
        ST_RUN: begin
          if (mem_access) begin
            freeze    = 1'b1;
            nextCnt   = LAT_LOAD;
            nextState = ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (cnt != 4'd0) begin
            freeze  = 1'b1;
            nextCnt = cnt - 4'd1;
          end else begin
            nextState = ST_RUN;
          end
        end
        default: nextState = ST_RUN;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_ADVANCE;
    if (rst)              ctrl = CTRL_RESET;
    else if (freeze)      ctrl = CTRL_FREEZE;
    else if (branchTaken) ctrl = CTRL_BRANCH;
    else if (loadUse)     ctrl = CTRL_LOADUSE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (!ctrl.pcEn && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign pc_en        = ctrl.pcEn;
  assign pc_sel       = ctrl.pcSel;
  assign ifid_en      = ctrl.ifidEn;
  assign ifid_flush   = ctrl.ifidFlush;
  assign idex_en      = ctrl.idexEn;
  assign idex_flush   = ctrl.idexFlush;
  assign exmem_en     = ctrl.exmemEn;
  assign exmem_flush  = ctrl.exmemFlush;
  assign memwb_en     = ctrl.memwbEn;
  assign stall_cycles = stallCnt;
  assign dbgState     = state;
  assign dbgCnt       = cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: one instance with a 2-cycle memory wait and a
// second with no wait and a 3-bit stall counter, driven by shared stimulus.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  // Vector order: pc_en,pc_sel,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,exmem_flush,memwb_en
  localparam logic [8:0] ADV = 9'b1_0_1_0_1_0_1_0_1;
  localparam logic [8:0] RST = 9'b0_0_0_1_0_1_0_1_0;
  localparam logic [8:0] FRZ = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] BR  = 9'b1_1_1_1_1_1_1_1_1;
  localparam logic [8:0] LU  = 9'b0_0_0_0_1_1_1_0_1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic ex_mem_read = 1'b0, mem_branch = 1'b0, mem_zf = 1'b0, mem_access = 1'b0;

  logic pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en;
  logic [15:0] stall_cycles;
  hazState_e   dbgState;
  logic [3:0]  dbgCnt;
  logic pc_en0, pc_sel0, ifid_en0, ifid_flush0, idex_en0, idex_flush0, exmem_en0, exmem_flush0,
        memwb_en0;
  logic [2:0]  stall_cycles0;
  hazState_e   dbgState0;
  logic [3:0]  dbgCnt0;

  logic [8:0] obsVec, obsVec0;
  assign obsVec  = {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                    exmem_flush, memwb_en};
  assign obsVec0 = {pc_en0, pc_sel0, ifid_en0, ifid_flush0, idex_en0, idex_flush0, exmem_en0,
                    exmem_flush0, memwb_en0};

  logic [8:0]  expQ[$];
  logic [8:0]  exp0Q[$];
  logic [15:0] expStall  = '0;
  logic [2:0]  expStall0 = '0;
  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zf(mem_zf), .mem_access(mem_access),
    .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .stall_cycles(stall_cycles),
    .dbgState(dbgState), .dbgCnt(dbgCnt)
  );

  pipeline_hazard_ctrl #(.MEM_LAT(0), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zf(mem_zf), .mem_access(mem_access),
    .pc_en(pc_en0), .pc_sel(pc_sel0), .ifid_en(ifid_en0), .ifid_flush(ifid_flush0),
    .idex_en(idex_en0), .idex_flush(idex_flush0), .exmem_en(exmem_en0),
    .exmem_flush(exmem_flush0), .memwb_en(memwb_en0), .stall_cycles(stall_cycles0),
    .dbgState(dbgState0), .dbgCnt(dbgCnt0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational expectation for RUN-state cycles with no memory access in play.
  function automatic logic [8:0] expComb(input logic br, input logic zf, input logic mr,
                                         input logic [4:0] ert, input logic [4:0] rs,
                                         input logic [4:0] rt);
    if (br && zf) return BR;
    if (mr && (ert != 5'd0) && ((ert == rs) || (ert == rt))) return LU;
    return ADV;
  endfunction

  // Drives one cycle, queues expectations, compares controls on the negedge and
  // stall counters just after the following posedge.
  task automatic step(input string name, input logic r, input logic [4:0] rs,
                      input logic [4:0] rt, input logic mr, input logic [4:0] ert,
                      input logic br, input logic zf, input logic acc,
                      input logic [8:0] e, input logic [8:0] e0);
    rst = r; id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = ert;
    mem_branch = br; mem_zf = zf; mem_access = acc;
    expQ.push_back(e);
    exp0Q.push_back(e0);
    if (r) begin
      expStall  = '0;
      expStall0 = '0;
    end else begin
      if (!e[8]  && expStall  != 16'hFFFF) expStall++;
      if (!e0[8] && expStall0 != 3'h7)     expStall0++;
    end
    @(negedge clk);
    check({name, ".ctrl"},  32'(obsVec),  32'(expQ.pop_front()));
    check({name, ".ctrl0"}, 32'(obsVec0), 32'(exp0Q.pop_front()));
    @(posedge clk);
    #1;
    check({name, ".stall"},  32'(stall_cycles),  32'(expStall));
    check({name, ".stall0"}, 32'(stall_cycles0), 32'(expStall0));
  endtask

  initial begin
    @(posedge clk);
    #1;
    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, RST, RST);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, RST, RST);
    step("adv",  0, 0, 0, 0, 0, 0, 0, 0, ADV, ADV);

    step("lu",      0, 5'd8, 5'd3, 1, 5'd8, 0, 0, 0, LU,  LU);
    step("lu_next", 0, 5'd8, 5'd3, 0, 5'd8, 0, 0, 0, ADV, ADV);
    check("lu_count", 32'(stall_cycles), 32'd1);
    step("lu_rt",   0, 5'd1, 5'd9, 1, 5'd9, 0, 0, 0, LU,  LU);
    step("lu_zero", 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, ADV, ADV);

    step("br",    0, 0, 0, 0, 0, 1, 1, 0, BR,  BR);
    step("br_nz", 0, 0, 0, 0, 0, 1, 0, 0, ADV, ADV);

    step("mem_f1",  0, 0, 0, 0, 0, 0, 0, 1, FRZ, ADV);
    step("mem_f2",  0, 0, 0, 0, 0, 0, 0, 1, FRZ, ADV);
    step("mem_rel", 0, 0, 0, 0, 0, 0, 0, 1, ADV, ADV);
    step("mem_end", 0, 0, 0, 0, 0, 0, 0, 0, ADV, ADV);

    step("pri_mlu_f1",  0, 5'd4, 0, 1, 5'd4, 0, 0, 1, FRZ, LU);
    step("pri_mlu_f2",  0, 5'd4, 0, 1, 5'd4, 0, 0, 1, FRZ, LU);
    step("pri_mlu_rel", 0, 5'd4, 0, 1, 5'd4, 0, 0, 1, LU,  LU);
    step("pri_mlu_end", 0, 5'd4, 0, 0, 5'd4, 0, 0, 0, ADV, ADV);
    step("pri_blu",     0, 5'd6, 0, 1, 5'd6, 1, 1, 0, BR,  BR);
    step("pri_mbr_f1",  0, 0, 0, 0, 0, 1, 1, 1, FRZ, BR);
    step("pri_mbr_f2",  0, 0, 0, 0, 0, 1, 1, 1, FRZ, BR);
    step("pri_mbr_rel", 0, 0, 0, 0, 0, 1, 1, 1, BR,  BR);
    step("pri_mbr_end", 0, 0, 0, 0, 0, 0, 0, 0, ADV, ADV);

    step("rstw_f1", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, ADV);
    check("rstw_state_wait", 32'(dbgState), 32'(ST_MEM_WAIT));
    step("rstw_rst", 1, 0, 0, 0, 0, 0, 0, 1, RST, RST);
    check("rstw_state", 32'(dbgState), 32'(ST_RUN));
    check("rstw_cnt",   32'(dbgCnt),   32'd0);
    step("rstw_adv", 0, 0, 0, 0, 0, 0, 0, 0, ADV, ADV);

    for (int i = 0; i < 40; i++) begin
      logic [4:0] rs, rt, ert;
      logic mr, br, zf;
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      ert = 5'($urandom_range(0, 3));
      mr  = 1'($urandom_range(0, 1));
      br  = 1'($urandom_range(0, 1));
      zf  = 1'($urandom_range(0, 1));
      step("rand", 0, rs, rt, mr, ert, br, zf, 0,
           expComb(br, zf, mr, ert, rs, rt), expComb(br, zf, mr, ert, rs, rt));
    end

    for (int i = 0; i < 9; i++) begin
      step("sat", 0, 5'd7, 0, 1, 5'd7, 0, 0, 0, LU, LU);
    end
    check("sat_hold", 32'(stall_cycles0), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "bench timeout");
  end

endmodule
